// File: rtl/iter_stream.sv
// iter_stream: walks an index 0..MAX_VALUE inclusive and presents each value
// as one beat of a valid/ready stream. A start pulse begins a run, abort
// cancels it, and done pulses for one cycle after the final beat is taken.
module iter_stream #(
   parameter int MAX_VALUE = 16,
   // MAX_VALUE == 0 still needs a 1-bit index, so the width is floored at 1
   parameter int WIDTH     = (MAX_VALUE < 1) ? 1 : $clog2(MAX_VALUE + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_val,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(MAX_VALUE);

   state_t           state;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_inc;
   logic             at_last;

   // Next index and terminal test; the increment is only used below LAST_IDX,
   // so it can never wrap even when LAST_IDX is all ones.
   always_comb begin
      count_inc = count + WIDTH'(1);
      at_last   = (count == LAST_IDX);
   end

   // Run sequencing plus all registered stream and status outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         out_valid <= 1'b0;
         out_val   <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // start takes priority over abort while idle
               if (start) begin
                  state     <= RUN;
                  count     <= '0;
                  out_valid <= 1'b1;
                  out_val   <= '0;
                  out_last  <= (LAST_IDX == '0);
                  busy      <= 1'b1;
               end
            end
            RUN: begin
               if (abort) begin
                  // a beat taken in this same cycle still counts, but no done
                  state     <= IDLE;
                  count     <= '0;
                  out_valid <= 1'b0;
                  out_val   <= '0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
               end else if (out_ready) begin
                  if (at_last) begin
                     state     <= IDLE;
                     count     <= '0;
                     out_valid <= 1'b0;
                     out_val   <= '0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     count    <= count_inc;
                     out_val  <= count_inc;
                     out_last <= (count_inc == LAST_IDX);
                  end
               end
            end
            default: begin
               state     <= IDLE;
               count     <= '0;
               out_valid <= 1'b0;
               out_val   <= '0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_stream.sv
// Bench for iter_stream: three instances (MAX_VALUE 4, 0, 15) share clock and
// reset. A driver issues directed then random stimulus and a reference model
// pushes expected beats into per-instance queues; a monitor pops and compares.
module tb_iter_stream;

   localparam int NI = 3;

   typedef struct {
      int unsigned val;
      bit          last;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NI-1:0]   start, abort, rdy;
   logic [NI-1:0]   ov, ol, bz, dn;
   logic [3:0]      val_w [NI];

   int checks   = 0;
   int failures = 0;

   // reference model state per instance
   bit          m_active [NI];
   int unsigned m_idx    [NI];
   bit          m_done   [NI];
   // expectations for the current cycle
   bit          e_valid  [NI];
   int unsigned e_val    [NI];
   bit          e_last   [NI];
   bit          e_done   [NI];
   beat_t       sb [NI][$];
   int          accepted [NI];

   always #5 clk = ~clk;

   function automatic int unsigned maxv(input int i);
      case (i)
         0:       return 4;
         1:       return 0;
         default: return 15;
      endcase
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int M = (g == 0) ? 4 : (g == 1) ? 0 : 15;
      localparam int W = (M < 1) ? 1 : $clog2(M + 1);
      logic [W-1:0] v;
      assign val_w[g] = 4'(v);
      iter_stream #(.MAX_VALUE(M)) u_dut (
         .clk       (clk),
         .reset     (rst_n),
         .start     (start[g]),
         .abort     (abort[g]),
         .out_valid (ov[g]),
         .out_ready (rdy[g]),
         .out_val   (v),
         .out_last  (ol[g]),
         .busy      (bz[g]),
         .done      (dn[g])
      );
   end

   task automatic check(input string name, input int i, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst=%0d (max=%0d) t=%0t actual=%0d expected=%0d",
                  name, i, maxv(i), $time, act, exp);
      end
   endtask

   // One cycle of stimulus: drive inputs, record what this cycle should show,
   // queue any beat the consumer takes, then advance the model.
   task automatic step(input logic rs, input logic [NI-1:0] st,
                       input logic [NI-1:0] ab, input logic [NI-1:0] rd);
      @(negedge clk);
      rst_n = rs;
      start = st;
      abort = ab;
      rdy   = rd;
      for (int i = 0; i < NI; i++) begin
         e_valid[i] = m_active[i];
         e_val[i]   = m_active[i] ? m_idx[i] : 0;
         e_last[i]  = m_active[i] && (m_idx[i] == maxv(i));
         e_done[i]  = m_done[i];
         if (rs && m_active[i] && rd[i]) begin
            sb[i].push_back('{val: m_idx[i], last: (m_idx[i] == maxv(i))});
            accepted[i]++;
         end
         m_done[i] = 1'b0;
         if (!rs) begin
            m_active[i] = 1'b0;
            m_idx[i]    = 0;
         end else if (m_active[i]) begin
            if (ab[i]) begin
               m_active[i] = 1'b0;
               m_idx[i]    = 0;
            end else if (rd[i]) begin
               if (m_idx[i] == maxv(i)) begin
                  m_active[i] = 1'b0;
                  m_idx[i]    = 0;
                  m_done[i]   = 1'b1;
               end else begin
                  m_idx[i] = m_idx[i] + 1;
               end
            end
         end else if (st[i]) begin
            m_active[i] = 1'b1;
            m_idx[i]    = 0;
         end
      end
   endtask

   task automatic idle_cycles(input int n, input logic [NI-1:0] rd);
      for (int k = 0; k < n; k++) step(1'b1, '0, '0, rd);
   endtask

   // Monitor: every cycle, shortly after the driver, compare status outputs and
   // pop the scoreboard on each accepted beat.
   initial begin
      beat_t b;
      forever begin
         @(negedge clk);
         #1;
         for (int i = 0; i < NI; i++) begin
            check("out_valid", i, ov[i], e_valid[i]);
            check("busy", i, bz[i], e_valid[i]);
            check("done", i, dn[i], e_done[i]);
            check("out_val", i, val_w[i], e_val[i]);
            check("out_last", i, ol[i], e_last[i]);
            if (rst_n && ov[i] && rdy[i]) begin
               if (sb[i].size() == 0) begin
                  check("beat_unexpected", i, 1, 0);
               end else begin
                  b = sb[i].pop_front();
                  check("beat_val", i, val_w[i], b.val);
                  check("beat_last", i, ol[i], b.last);
               end
            end
         end
      end
   end

   initial begin
      logic [NI-1:0] st, ab, rd;
      for (int i = 0; i < NI; i++) begin
         m_active[i] = 1'b0; m_idx[i] = 0; m_done[i] = 1'b0;
         e_valid[i] = 1'b0; e_val[i] = 0; e_last[i] = 1'b0; e_done[i] = 1'b0;
         accepted[i] = 0;
      end
      rst_n = 1'b0; start = '0; abort = '0; rdy = '0;

      // reset held with start high, then idle
      for (int k = 0; k < 3; k++) step(1'b0, '1, '0, '1);
      idle_cycles(2, '1);

      // full run at full throughput
      step(1'b1, '1, '0, '1);
      idle_cycles(20, '1);

      // backpressure after two beats
      step(1'b1, '1, '0, '1);
      idle_cycles(2, '1);
      idle_cycles(3, '0);
      idle_cycles(20, '1);

      // abort mid-run, then restart from 0
      step(1'b1, '1, '0, '1);
      idle_cycles(2, '1);
      step(1'b1, '0, '1, '0);
      idle_cycles(2, '1);
      step(1'b1, '1, '0, '1);
      idle_cycles(20, '1);

      // abort coinciding with a handshake
      step(1'b1, '1, '0, '1);
      step(1'b1, '0, '1, '1);
      idle_cycles(2, '1);

      // start held high across runs: back-to-back with a 1-cycle gap
      for (int k = 0; k < 40; k++) step(1'b1, '1, '0, '1);

      // start and abort together while idle
      idle_cycles(2, '1);
      step(1'b1, '1, '1, '0);
      idle_cycles(20, '1);

      // reset in the middle of a run
      step(1'b1, '1, '0, '1);
      idle_cycles(2, '1);
      step(1'b0, '0, '0, '1);
      idle_cycles(3, '1);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < NI; i++) begin
            st[i] = ($urandom_range(3) == 0);
            ab[i] = ($urandom_range(15) == 0);
            rd[i] = ($urandom_range(3) != 0);
         end
         step(($urandom_range(199) != 0), st, ab, rd);
      end

      // drain and confirm every expected beat was seen
      step(1'b1, '0, '1, '0);
      idle_cycles(3, '1);
      @(negedge clk);
      #2;
      for (int i = 0; i < NI; i++) begin
         check("scoreboard_empty", i, sb[i].size(), 0);
         if (accepted[i] == 0) check("beats_seen", i, 0, 1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
